// File: rtl/uidbuf_wch.sv
// Write-channel frame buffer: pixel words enter a show-ahead FIFO and drain to FDMA in fixed bursts.
// Optional dropped-word counter enabled by defining UIDBUF_WCH_OVF_CNT_EN.
module uidbuf_wch #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 21,
  parameter int BURST_LEN      = 256,
  parameter int FRAME_WORDS    = 1024,
  parameter int FIFO_DEPTH     = 512,
  parameter int BUF_NUM        = 3,
  parameter int BUF_BASE       = 0,
  parameter int BUF_STRIDE     = 'h80000
) (
  input  logic                      ui_clk,
  input  logic                      ui_rstn,
  input  logic                      W_FS_i,
  input  logic                      W_wren_i,
  input  logic [AXI_DATA_WIDTH-1:0] W_data_i,
  output logic                      W_full_o,
  output logic [1:0]                W_bufn_o,
  output logic                      W_fdone_o,
  output logic [15:0]               W_ovf_cnt_o,
  output logic [AXI_ADDR_WIDTH-1:0] fdma_waddr,
  output logic                      fdma_wareq,
  output logic [15:0]               fdma_wsize,
  input  logic                      fdma_wbusy,
  output logic [AXI_DATA_WIDTH-1:0] fdma_wdata,
  input  logic                      fdma_wvalid
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int BPF  = FRAME_WORDS / BURST_LEN;
  localparam int BCW  = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int BYTES_PER_BURST = BURST_LEN * (AXI_DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

  function automatic logic [AXI_ADDR_WIDTH-1:0] burst_addr(input logic [1:0] idx,
                                                           input logic [BCW-1:0] cnt);
    burst_addr = AXI_ADDR_WIDTH'(BUF_BASE)
               + AXI_ADDR_WIDTH'(idx) * AXI_ADDR_WIDTH'(BUF_STRIDE)
               + AXI_ADDR_WIDTH'(cnt) * AXI_ADDR_WIDTH'(BYTES_PER_BURST);
  endfunction

  state_t                      state_q, state_d;
  logic [AXI_DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]             count_q, count_d;
  logic                        wareq_q, wareq_d;
  logic [AXI_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [BCW-1:0]              burst_cnt_q, burst_cnt_d;
  logic [1:0]                  buf_idx_q, buf_idx_d, bufn_q, bufn_d;
  logic                        fdone_q, fdone_d, fs_pend_q, fs_pend_d;
  logic                        fs_prev_q, wbusy_prev_q;
  logic                        full_s, empty_s, fs_rise_s, flush_s, push_s, pop_s;

  assign fdma_wsize = 16'(BURST_LEN);
  assign fdma_wareq = wareq_q;
  assign fdma_waddr = waddr_q;
  assign W_full_o   = full_s;
  assign W_bufn_o   = bufn_q;
  assign W_fdone_o  = fdone_q;
  assign fdma_wdata = empty_s ? {AXI_DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];

  always_comb begin
    full_s    = (count_q == CNTW'(FIFO_DEPTH));
    empty_s   = (count_q == CNTW'(0));
    fs_rise_s = W_FS_i & ~fs_prev_q;
    // A pending frame start wipes the FIFO, so nothing moves in that cycle.
    flush_s   = (state_q == S_IDLE) && fs_pend_q;
    push_s    = W_wren_i && !full_s && !flush_s;
    pop_s     = fdma_wvalid && !empty_s && !flush_s;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wareq_d     = wareq_q;
    burst_cnt_d = burst_cnt_q;
    buf_idx_d   = buf_idx_q;
    bufn_d      = bufn_q;
    fdone_d     = 1'b0;
    fs_pend_d   = fs_pend_q | fs_rise_s;

    if (flush_s) begin
      wr_ptr_d = PW'(0);
      rd_ptr_d = PW'(0);
      count_d  = CNTW'(0);
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (fs_pend_q) begin
          burst_cnt_d = BCW'(0);
          fs_pend_d   = fs_rise_s;
        end else if ((count_q >= CNTW'(BURST_LEN)) && !fs_rise_s) begin
          state_d = S_REQ;
          wareq_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (fdma_wbusy) begin
          wareq_d = 1'b0;
          state_d = S_BUSY;
        end else begin
          wareq_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (wbusy_prev_q && !fdma_wbusy) begin
          state_d = S_IDLE;
          if (burst_cnt_q == BCW'(BPF - 1)) begin
            burst_cnt_d = BCW'(0);
            bufn_d      = buf_idx_q;
            buf_idx_d   = (buf_idx_q == 2'(BUF_NUM - 1)) ? 2'd0 : buf_idx_q + 2'd1;
            fdone_d     = 1'b1;
          end else begin
            burst_cnt_d = burst_cnt_q + BCW'(1);
          end
        end else begin
          state_d = S_BUSY;
        end
      end
      default: begin
        state_d = S_IDLE;
        wareq_d = 1'b0;
      end
    endcase

    // Address tracks the next burst position so it is already stable when a request rises.
    waddr_d = burst_addr(buf_idx_d, burst_cnt_d);
  end

  always_ff @(posedge ui_clk) begin
    if (push_s) mem_q[wr_ptr_q] <= W_data_i;
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= PW'(0);
      rd_ptr_q     <= PW'(0);
      count_q      <= CNTW'(0);
      wareq_q      <= 1'b0;
      waddr_q      <= burst_addr(2'd0, BCW'(0));
      burst_cnt_q  <= BCW'(0);
      buf_idx_q    <= 2'd0;
      bufn_q       <= 2'd0;
      fdone_q      <= 1'b0;
      fs_pend_q    <= 1'b0;
      fs_prev_q    <= 1'b0;
      wbusy_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wareq_q      <= wareq_d;
      waddr_q      <= waddr_d;
      burst_cnt_q  <= burst_cnt_d;
      buf_idx_q    <= buf_idx_d;
      bufn_q       <= bufn_d;
      fdone_q      <= fdone_d;
      fs_pend_q    <= fs_pend_d;
      fs_prev_q    <= W_FS_i;
      wbusy_prev_q <= fdma_wbusy;
    end
  end

`ifdef UIDBUF_WCH_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic        drop_s;

  always_comb begin
    drop_s    = W_wren_i && full_s && !flush_s;
    ovf_cnt_d = ovf_cnt_q;
    if (flush_s)                             ovf_cnt_d = 16'd0;
    else if (drop_s && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    else                                     ovf_cnt_d = ovf_cnt_q;
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) ovf_cnt_q <= 16'd0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end

  assign W_ovf_cnt_o = ovf_cnt_q;
`else
  assign W_ovf_cnt_o = 16'd0;
`endif

endmodule
